// File: rtl/dp_ram.sv
// Simple true dual-port block RAM with registered read data.
// Each port is read-first; both ports share one storage array.
module dp_ram #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 12
) (
    input  logic               clk,
    input  logic [A_WIDTH-1:0] addr_a,
    input  logic [D_WIDTH-1:0] wdata_a,
    input  logic               wr_a,
    output logic [D_WIDTH-1:0] rdata_a,
    input  logic [A_WIDTH-1:0] addr_b,
    input  logic [D_WIDTH-1:0] wdata_b,
    input  logic               wr_b,
    output logic [D_WIDTH-1:0] rdata_b
);

    logic [D_WIDTH-1:0] mem [2**A_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_a) begin
            mem[addr_a] <= wdata_a;
        end
        rdata_a <= mem[addr_a];
    end

    always_ff @(posedge clk) begin
        if (wr_b) begin
            mem[addr_b] <= wdata_b;
        end
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/dp_ram_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req_i scanning from ptr_i
// upwards with wrap at N, reported as onehot, index and any-flag.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int W = $clog2(N);

    int         s;
    logic [W-1:0] j;
    logic       found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        s     = 0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            s = int'(ptr_i) + k;
            if (s >= N) begin
                s = s - N;
            end
            j = W'(s);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/dp_ram_arbiter.sv
// Shares both ports of a dual-port RAM among N_REQ requesters,
// granting up to two requests per cycle in round-robin order.
module dp_ram_arbiter #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 12,
    parameter int N_REQ   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_wr,
    input  logic [N_REQ*A_WIDTH-1:0] req_addr,
    input  logic [N_REQ*D_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [N_REQ*D_WIDTH-1:0] rsp_rdata,
    output logic [A_WIDTH-1:0]       ram_addr_a,
    output logic [D_WIDTH-1:0]       ram_wdata_a,
    output logic                     ram_wr_a,
    input  logic [D_WIDTH-1:0]       ram_rdata_a,
    output logic [A_WIDTH-1:0]       ram_addr_b,
    output logic [D_WIDTH-1:0]       ram_wdata_b,
    output logic                     ram_wr_b,
    input  logic [D_WIDTH-1:0]       ram_rdata_b
);

    localparam int RR_W = $clog2(N_REQ);
    localparam logic [RR_W-1:0] LAST = RR_W'(N_REQ - 1);

    function automatic logic [RR_W-1:0] wrap_inc(
        input logic [RR_W-1:0] v
    );
        return (v == LAST) ? '0 : v + 1'b1;
    endfunction

    logic [A_WIDTH-1:0] addr_s  [N_REQ];
    logic [D_WIDTH-1:0] wdata_s [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign addr_s[g]  = req_addr[g*A_WIDTH +: A_WIDTH];
        assign wdata_s[g] = req_wdata[g*D_WIDTH +: D_WIDTH];
    end

    logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] gnt_a_oh, gnt_b_oh;
    logic [RR_W-1:0]  idx_a, idx_b;
    logic             any_a, any_b;

    rr_pick #(.N(N_REQ)) u_pick_a (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_a_oh),
        .idx_o (idx_a),
        .any_o (any_a)
    );

    // Port B picks the next valid requester after port A's choice.
    rr_pick #(.N(N_REQ)) u_pick_b (
        .req_i (req_valid & ~gnt_a_oh),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_b_oh),
        .idx_o (idx_b),
        .any_o (any_b)
    );

    logic [A_WIDTH-1:0] addr_a, addr_b;
    logic [D_WIDTH-1:0] wdata_a, wdata_b;
    logic               wr_a, wr_b;
    logic               conflict;
    logic               use_a, use_b;

    assign addr_a  = addr_s[idx_a];
    assign addr_b  = addr_s[idx_b];
    assign wdata_a = wdata_s[idx_a];
    assign wdata_b = wdata_s[idx_b];
    assign wr_a    = req_wr[idx_a];
    assign wr_b    = req_wr[idx_b];

    // Same-address access with any write keeps only port A.
    assign conflict = any_a && any_b && (addr_a == addr_b)
                    && (wr_a || wr_b);

    assign use_a = rst_n && any_a;
    assign use_b = rst_n && any_b && !conflict;

    assign req_ready = ({N_REQ{use_a}} & gnt_a_oh)
                     | ({N_REQ{use_b}} & gnt_b_oh);

    assign ram_addr_a  = use_a ? addr_a  : '0;
    assign ram_wdata_a = use_a ? wdata_a : '0;
    assign ram_wr_a    = use_a && wr_a;
    assign ram_addr_b  = use_b ? addr_b  : '0;
    assign ram_wdata_b = use_b ? wdata_b : '0;
    assign ram_wr_b    = use_b && wr_b;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (use_b) begin
            rr_ptr_d = wrap_inc(idx_b);
        end else if (use_a) begin
            rr_ptr_d = wrap_inc(idx_a);
        end
    end

    logic            rd_vld_a_q, rd_vld_a_d;
    logic            rd_vld_b_q, rd_vld_b_d;
    logic [RR_W-1:0] rd_idx_a_q, rd_idx_b_q;

    assign rd_vld_a_d = use_a && !wr_a;
    assign rd_vld_b_d = use_b && !wr_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            rd_vld_a_q <= 1'b0;
            rd_vld_b_q <= 1'b0;
            rd_idx_a_q <= '0;
            rd_idx_b_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rd_vld_a_q <= rd_vld_a_d;
            rd_vld_b_q <= rd_vld_b_d;
            rd_idx_a_q <= idx_a;
            rd_idx_b_q <= idx_b;
        end
    end

    logic hit_a, hit_b;

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        hit_a     = 1'b0;
        hit_b     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            hit_a = rst_n && rd_vld_a_q && (rd_idx_a_q == RR_W'(i));
            hit_b = rst_n && rd_vld_b_q && (rd_idx_b_q == RR_W'(i));
            if (hit_a) begin
                rsp_valid[i] = 1'b1;
                rsp_rdata[i*D_WIDTH +: D_WIDTH] = ram_rdata_a;
            end else if (hit_b) begin
                rsp_valid[i] = 1'b1;
                rsp_rdata[i*D_WIDTH +: D_WIDTH] = ram_rdata_b;
            end
        end
    end

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Directed bench: arbiter in front of a dual-port RAM, N_REQ=4,
// hand-computed expectations for grants, conflicts and responses.
module tb_dp_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NR = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req_valid, req_wr, req_ready, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata, rsp_rdata;
    logic [AW-1:0]  ram_addr_a, ram_addr_b;
    logic [DW-1:0]  ram_wdata_a, ram_wdata_b;
    logic [DW-1:0]  ram_rdata_a, ram_rdata_b;
    logic           ram_wr_a, ram_wr_b;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dp_ram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW), .N_REQ(NR)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .ram_addr_a  (ram_addr_a),
        .ram_wdata_a (ram_wdata_a),
        .ram_wr_a    (ram_wr_a),
        .ram_rdata_a (ram_rdata_a),
        .ram_addr_b  (ram_addr_b),
        .ram_wdata_b (ram_wdata_b),
        .ram_wr_b    (ram_wr_b),
        .ram_rdata_b (ram_rdata_b)
    );

    dp_ram #(.D_WIDTH(DW), .A_WIDTH(AW)) u_ram (
        .clk     (clk),
        .addr_a  (ram_addr_a),
        .wdata_a (ram_wdata_a),
        .wr_a    (ram_wr_a),
        .rdata_a (ram_rdata_a),
        .addr_b  (ram_addr_b),
        .wdata_b (ram_wdata_b),
        .wr_b    (ram_wr_b),
        .rdata_b (ram_rdata_b)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic put(input int i, input logic wr,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        req_valid[i]         = 1'b1;
        req_wr[i]            = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] slice(input int i);
        return rsp_rdata[i*DW +: DW];
    endfunction

    int           cnt [NR];
    logic [NR-1:0] prev;

    initial begin
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < NR; i++) begin
            put(i, 1'b1, AW'(12'h300 + i), 32'h1);
        end

        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_wr_a", 32'(ram_wr_a), 32'h0);
            chk("rst_wr_b", 32'(ram_wr_b), 32'h0);
            chk("rst_rsp", 32'(rsp_valid), 32'h0);
        end

        tick();
        rst_n = 1'b1;
        idle();

        // preload through both ports; grants (2,3) leave rr_ptr at 0
        tick();
        put(2, 1'b1, 12'h010, 32'hAAAA);
        put(3, 1'b1, 12'h020, 32'hBBBB);
        #1;
        chk("pre_ready", 32'(req_ready), 32'hC);
        chk("pre_wr_a", 32'(ram_wr_a), 32'h1);
        chk("pre_addr_a", 32'(ram_addr_a), 32'h010);
        chk("pre_wr_b", 32'(ram_wr_b), 32'h1);
        chk("pre_addr_b", 32'(ram_addr_b), 32'h020);

        tick();
        idle();
        put(1, 1'b0, 12'h010, 32'h0);
        put(3, 1'b0, 12'h020, 32'h0);
        #1;
        chk("two_ready", 32'(req_ready), 32'hA);
        chk("two_addr_a", 32'(ram_addr_a), 32'h010);
        chk("two_addr_b", 32'(ram_addr_b), 32'h020);
        chk("two_wr_a", 32'(ram_wr_a), 32'h0);

        tick();
        idle();
        #1;
        chk("two_rsp", 32'(rsp_valid), 32'hA);
        chk("two_s1", slice(1), 32'hAAAA);
        chk("two_s3", slice(3), 32'hBBBB);
        chk("two_s0", slice(0), 32'h0);

        prev = '0;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                put(i, 1'b0, AW'(12'h100 + i), 32'h0);
            end
            #1;
            chk("fair_ready", 32'(req_ready),
                (c % 2 == 0) ? 32'h3 : 32'hC);
            chk("fair_rsp", 32'(rsp_valid), 32'(prev));
            prev = req_ready;
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) cnt[i]++;
            end
        end
        for (int i = 0; i < NR; i++) begin
            chk("fair_cnt", 32'(cnt[i]), 32'd3);
        end

        tick();
        idle();
        #1;
        chk("fair_last", 32'(rsp_valid), 32'hC);

        // write/read collision on 0x040: port B must be dropped
        tick();
        put(0, 1'b1, 12'h040, 32'h5);
        put(1, 1'b0, 12'h040, 32'h0);
        #1;
        chk("cf_ready", 32'(req_ready), 32'h1);
        chk("cf_wr_a", 32'(ram_wr_a), 32'h1);
        chk("cf_wdata_a", ram_wdata_a, 32'h5);
        chk("cf_wr_b", 32'(ram_wr_b), 32'h0);
        chk("cf_addr_b", 32'(ram_addr_b), 32'h0);

        tick();
        req_valid[0] = 1'b0;
        req_wr[0]    = 1'b0;
        #1;
        chk("cf_retry", 32'(req_ready), 32'h2);
        chk("cf_addr_a", 32'(ram_addr_a), 32'h040);

        tick();
        idle();
        #1;
        chk("cf_rsp", 32'(rsp_valid), 32'h2);
        chk("cf_s1", slice(1), 32'h5);

        tick();
        put(2, 1'b1, 12'h7FF, 32'hCAFEF00D);
        #1;
        chk("sa_wready", 32'(req_ready), 32'h4);

        tick();
        idle();
        put(2, 1'b0, 12'h7FF, 32'h0);
        put(3, 1'b0, 12'h7FF, 32'h0);
        #1;
        chk("sa_ready", 32'(req_ready), 32'hC);
        chk("sa_addr_b", 32'(ram_addr_b), 32'h7FF);

        tick();
        idle();
        #1;
        chk("sa_rsp", 32'(rsp_valid), 32'hC);
        chk("sa_s2", slice(2), 32'hCAFEF00D);
        chk("sa_s3", slice(3), 32'hCAFEF00D);

        // read granted, then reset lands on its response cycle
        tick();
        put(0, 1'b0, 12'h010, 32'h0);
        #1;
        chk("mr_ready", 32'(req_ready), 32'h1);

        tick();
        rst_n = 1'b0;
        idle();
        put(2, 1'b1, 12'h055, 32'h9);
        #1;
        chk("mr_rsp", 32'(rsp_valid), 32'h0);
        chk("mr_s0", slice(0), 32'h0);
        chk("mr_ready0", 32'(req_ready), 32'h0);
        chk("mr_wr_a", 32'(ram_wr_a), 32'h0);

        tick();
        rst_n = 1'b1;
        idle();
        #1;
        chk("mr_after", 32'(rsp_valid), 32'h0);

        tick();
        put(0, 1'b0, 12'h020, 32'h0);
        put(3, 1'b0, 12'h010, 32'h0);
        #1;
        chk("mr_ready2", 32'(req_ready), 32'h9);
        chk("mr_addr_a", 32'(ram_addr_a), 32'h020);
        chk("mr_addr_b", 32'(ram_addr_b), 32'h010);

        tick();
        idle();
        #1;
        chk("mr_rsp2", 32'(rsp_valid), 32'h9);
        chk("mr_s0b", slice(0), 32'hBBBB);
        chk("mr_s3b", slice(3), 32'hAAAA);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_mis);
        $finish;
    end

endmodule
